// File: rtl/memory_pkg.sv
// Shared word/address widths and the access FSM state type for multimemory.
package memory_pkg;

  localparam int WORD_W = 36;
  localparam int ADDR_W = 18;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker: the first requesting port at or after ptr,
// wrapping modulo NPORTS. Purely combinational; the caller registers the result.
module rr_arbiter #(
  parameter int NPORTS = 2,
  parameter int IDX_W  = 1
) (
  input  logic [NPORTS-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NPORTS-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx
);

  int   pos;
  logic found;

  // Scan the ports starting at ptr and take the first one that is requesting.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = 0;
    for (int k = 0; k < NPORTS; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NPORTS) pos = pos - NPORTS;
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        grant_idx  = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/multimemory.sv
// multimemory: NPORTS Avalon-style masters sharing one 36-bit word array.
// One access at a time, round-robin fairness, DLY wait cycles per access.
// Valid/ready contract: a master raises i_read/i_write and holds address and
// data until it sees o_waitrequest low for one cycle; that cycle is the
// completion (write lands on that edge, read data is valid in that cycle).
// Dropping the request before completion aborts the access with no effect.
// Optional MULTIMEMORY_NXM_EN adds o_nxm, a one-cycle flag on completion of an
// access whose address falls outside the array window.
module multimemory
  import memory_pkg::*;
#(
  parameter int                NPORTS = 2,
  parameter int                ABITS  = 14,
  parameter logic [ADDR_W-1:0] BASE   = '0,
  parameter int                DLY    = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [ADDR_W*NPORTS-1:0] i_address,
  input  logic [NPORTS-1:0]        i_write,
  input  logic [NPORTS-1:0]        i_read,
  input  logic [WORD_W*NPORTS-1:0] i_writedata,
  output logic [WORD_W*NPORTS-1:0] o_readdata,
  output logic [NPORTS-1:0]        o_waitrequest
`ifdef MULTIMEMORY_NXM_EN
  ,
  output logic [NPORTS-1:0]        o_nxm
`endif
);

  localparam int                IDX_W    = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int                DEPTH    = 2 ** ABITS;
  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NPORTS - 1);
  localparam logic [3:0]        CNT_LOAD = 4'(DLY);

  // FSM and bookkeeping flops
  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [3:0]       cnt_q, cnt_d;

  // Arbitration
  logic [NPORTS-1:0] req;
  logic [NPORTS-1:0] arb_grant;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_any;

  assign req     = i_read | i_write;
  assign arb_any = |arb_grant;

  rr_arbiter #(
    .NPORTS (NPORTS),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // Granted-port view of the bus and the array
  logic [ADDR_W-1:0] sel_addr;
  logic [ADDR_W-1:0] offset;
  logic [WORD_W-1:0] sel_wdata;
  logic              sel_req;
  logic              sel_wr;
  logic              in_range;
  logic [ABITS-1:0]  index;
  logic              complete;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rd;
  logic [IDX_W-1:0]  ptr_next;

  logic [WORD_W-1:0] mem [DEPTH];

  // Select the granted master's signals and decode its address into the window.
  always_comb begin
    sel_addr  = i_address[int'(grant_q)*ADDR_W +: ADDR_W];
    sel_wdata = i_writedata[int'(grant_q)*WORD_W +: WORD_W];
    sel_req   = req[grant_q];
    sel_wr    = i_write[grant_q];
    offset    = sel_addr - BASE;
    in_range  = ({1'b0, offset} < DEPTH_W);
    index     = offset[ABITS-1:0];
    complete  = (state_q == ACCESS) && sel_req && (cnt_q == 4'd0);
    mem_we    = complete && sel_wr && in_range;
    mem_rd    = mem[index];
    ptr_next  = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);
  end

  // State register: FSM, grant, round-robin pointer and wait counter.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: arbitrate in IDLE, count down in ACCESS, abort on request drop.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d = arb_idx;
          cnt_d   = CNT_LOAD;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!sel_req) begin
          // Abort: pointer stays where it was so fairness is unaffected.
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = 4'd0;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = ptr_next;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Outputs: every port stalls except the granted one in its completion cycle.
  always_comb begin
    o_waitrequest = '1;
    o_readdata    = '0;
`ifdef MULTIMEMORY_NXM_EN
    o_nxm         = '0;
`endif
    if (complete) begin
      o_waitrequest[grant_q] = 1'b0;
      if (!sel_wr && in_range) begin
        o_readdata[int'(grant_q)*WORD_W +: WORD_W] = mem_rd;
      end
`ifdef MULTIMEMORY_NXM_EN
      o_nxm[grant_q] = !in_range;
`endif
    end
  end

  // Array write on the completion edge; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[index] <= sel_wdata;
    end
  end

endmodule
